// File: rtl/dm_pkg.sv
// Shared types and default geometry for the clearable simple-dual-port data memory.
package dm_pkg;

  localparam int DM_DATA_W = 8;
  localparam int DM_ADDR_W = 8;
  localparam int DM_DEPTH  = 256;

  typedef enum logic {
    CLEAR,
    RUN
  } dm_state_e;

endpackage

// File: rtl/dm_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on storage.
module dm_ram_sdp #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WRITE_FIRST = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;

  always_comb begin
    rd_d = rd_q;
    if (re) begin
      // Same-address collision forwards the incoming word only in write-first mode.
      if ((WRITE_FIRST != 0) && we && (wa == ra)) rd_d = wd;
      else                                        rd_d = mem_q[ra];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
    rd_q <= rd_d;
  end

  assign rd = rd_q;

endmodule

// File: rtl/data_mem_sdp.sv
// Data memory with self-clearing sequence, range checking and registered read port.
module data_mem_sdp
  import dm_pkg::*;
#(
  parameter int DATA_W      = DM_DATA_W,
  parameter int DEPTH       = DM_DEPTH,
  parameter int ADDR_W      = DM_ADDR_W,
  parameter int WRITE_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  dm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              r_valid_q, r_valid_d;
  logic              err_q, err_d;
  logic              zero_q, zero_d;

  logic              w_ok, r_ok;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;
  logic [DATA_W-1:0] ram_rd;

  always_comb begin
    w_ok      = ({1'b0, w_addr} < DEPTH_X);
    r_ok      = ({1'b0, r_addr} < DEPTH_X);
    state_d   = state_q;
    ptr_d     = ptr_q;
    r_valid_d = 1'b0;
    err_d     = 1'b0;
    zero_d    = zero_q;
    ram_we    = 1'b0;
    ram_wa    = w_addr;
    ram_wd    = w_data;
    ram_re    = 1'b0;

    case (state_q)
      CLEAR: begin
        ram_we = 1'b1;
        ram_wa = ptr_q;
        ram_wd = '0;
        if (ptr_q == LAST) begin
          state_d = RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      RUN: begin
        ram_we    = w_en & w_ok;
        ram_re    = r_en & r_ok;
        r_valid_d = r_en;
        err_d     = (w_en & ~w_ok) | (r_en & ~r_ok);
        if (r_en) zero_d = ~r_ok;
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // The RAM output register carries no reset; zero_q masks it after reset and
  // after out-of-range reads so the storage can still map to block RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      r_valid_q <= 1'b0;
      err_q     <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      r_valid_q <= r_valid_d;
      err_q     <= err_d;
      zero_q    <= zero_d;
    end
  end

  dm_ram_sdp #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .wa  (ram_wa),
    .wd  (ram_wd),
    .re  (ram_re),
    .ra  (r_addr),
    .rd  (ram_rd)
  );

  assign busy    = (state_q == CLEAR);
  assign r_data  = zero_q ? '0 : ram_rd;
  assign r_valid = r_valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_data_mem_sdp.sv
// Directed bench for data_mem_sdp: default, read-first and DEPTH=200 variants driven in lockstep.
module tb_data_mem_sdp;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_req;
  logic       w_en, r_en;
  logic [7:0] w_addr, r_addr, w_data;

  logic       busy0, busy1, busy2;
  logic [7:0] r_data0, r_data1, r_data2;
  logic       r_valid0, r_valid1, r_valid2;
  logic       err0, err1, err2;

  int n_checks = 0;
  int n_fail   = 0;
  int n0, n1, n2;

  always #5 clk = ~clk;

  data_mem_sdp u_dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data0), .r_valid(r_valid0), .err(err0)
  );

  data_mem_sdp #(.WRITE_FIRST(0)) u_dut_rf (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data1), .r_valid(r_valid1), .err(err1)
  );

  data_mem_sdp #(.DEPTH(200)) u_dut_d200 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy2),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data2), .r_valid(r_valid2), .err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    w_en = 1'b1; w_addr = a; w_data = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    r_en = 1'b1; r_addr = a;
    tick();
    r_en = 1'b0;
  endtask

  task automatic count_busy(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!(busy0 | busy1 | busy2)) break;
      c0 += int'(busy0); c1 += int'(busy1); c2 += int'(busy2);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0; w_en = 1'b0; r_en = 1'b0;
    w_addr = '0; r_addr = '0; w_data = '0;
    repeat (3) tick();
    check("rst_busy",    busy0,    1);
    check("rst_r_data",  r_data0,  0);
    check("rst_r_valid", r_valid0, 0);
    check("rst_err",     err0,     0);

    rst = 1'b0;
    count_busy(n0, n1, n2);
    check("init_clr_len",      n0, 256);
    check("init_clr_len_rf",   n1, 256);
    check("init_clr_len_d200", n2, 200);
    check("busy_low", busy0, 0);

    do_read(8'd0);
    check("rd0_data", r_data0, 0);
    check("rd0_valid", r_valid0, 1);
    check("rd0_err", err0, 0);
    do_read(8'd127);
    check("rd127_data", r_data0, 0);
    do_read(8'd255);
    check("rd255_data", r_data0, 0);
    check("rd255_err", err0, 0);
    check("d200_rd255_data", r_data2, 0);
    check("d200_rd255_valid", r_valid2, 1);
    check("d200_rd255_err", err2, 1);
    tick();
    check("valid_drop", r_valid0, 0);
    check("d200_err_drop", err2, 0);

    do_write(8'h10, 8'hA5);
    do_read(8'h10);
    check("rd10_data", r_data0, 8'hA5);
    check("rd10_valid", r_valid0, 1);
    tick();
    check("idle_valid", r_valid0, 0);
    check("idle_hold", r_data0, 8'hA5);

    do_write(8'h20, 8'h11);
    w_en = 1'b1; w_addr = 8'h20; w_data = 8'h3C;
    r_en = 1'b1; r_addr = 8'h20;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    check("coll_wf", r_data0, 8'h3C);
    check("coll_rf", r_data1, 8'h11);
    check("coll_d200", r_data2, 8'h3C);
    do_read(8'h20);
    check("coll_rf_after", r_data1, 8'h3C);

    do_write(8'd210, 8'h77);
    check("d200_wr210_err", err2, 1);
    check("wr210_err", err0, 0);
    tick();
    check("d200_wr_err_drop", err2, 0);
    do_read(8'd10);
    check("d200_no_alias", r_data2, 0);
    do_read(8'd210);
    check("d200_rd210_data", r_data2, 0);
    check("d200_rd210_valid", r_valid2, 1);
    check("d200_rd210_err", err2, 1);
    check("rd210_data", r_data0, 8'h77);
    do_write(8'd199, 8'h5A);
    check("d200_wr199_err", err2, 0);
    do_read(8'd199);
    check("d200_rd199_data", r_data2, 8'h5A);
    check("d200_rd199_err", err2, 0);

    w_en = 1'b1; w_addr = 8'd220; w_data = 8'h01;
    r_en = 1'b1; r_addr = 8'd230;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    check("d200_both_oor_err", err2, 1);
    check("d200_both_oor_data", r_data2, 0);
    tick();
    check("d200_both_oor_single", err2, 0);

    do_write(8'h05, 8'hFF);
    do_read(8'h05);
    check("rd05_pre", r_data0, 8'hFF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_busy", busy0, 1);
    n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!(busy0 | busy1 | busy2)) break;
      n0 += int'(busy0); n1 += int'(busy1); n2 += int'(busy2);
      if (i == 2) begin
        w_en = 1'b1; w_addr = 8'h01; w_data = 8'hEE;
        r_en = 1'b1; r_addr = 8'h05;
      end
      tick();
      if (i == 2) begin
        w_en = 1'b0; r_en = 1'b0;
        check("clr_rd_valid", r_valid0, 0);
        check("clr_rd_err", err0, 0);
        check("clr_rd_hold", r_data0, 8'hFF);
      end
    end
    check("clr_len",      n0, 256);
    check("clr_len_rf",   n1, 256);
    check("clr_len_d200", n2, 200);
    do_read(8'h05);
    check("rd05_cleared", r_data0, 0);
    do_read(8'h01);
    check("rd01_ignored", r_data0, 0);
    check("d200_rd01_ignored", r_data2, 0);

    do_write(8'h30, 8'h42);
    do_read(8'h30);
    check("rd30_pre", r_data0, 8'h42);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (99) tick();
    check("midclr_busy", busy0, 1);
    check("midclr_hold", r_data0, 8'h42);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy0, 1);
    check("rst_mid_r_data", r_data0, 0);
    check("rst_mid_r_valid", r_valid0, 0);
    tick();
    rst = 1'b0;
    count_busy(n0, n1, n2);
    check("reclr_len",      n0, 256);
    check("reclr_len_rf",   n1, 256);
    check("reclr_len_d200", n2, 200);
    do_read(8'h30);
    check("rd30_cleared", r_data0, 0);
    check("rd30_valid", r_valid0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_sdp.md
DATA_MEM_SDP -- requirements
Module: data_mem_sdp

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 256, number of words; 2 <= DEPTH <= 2**ADDR_W.
REQ-003 Parameter ADDR_W, default 8, address width in bits.
REQ-004 Parameter WRITE_FIRST, default 1; 1 = same-address read returns new data, 0 = returns old data.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 clr_req  input  1  single-cycle pulse requesting a full memory clear.
REQ-008 busy  output  1  high while the clear sequence runs.
REQ-009 w_en  input  1  write request.
REQ-010 w_addr  input  ADDR_W  write address.
REQ-011 w_data  input  DATA_W  write data.
REQ-012 r_en  input  1  read request.
REQ-013 r_addr  input  ADDR_W  read address.
REQ-014 r_data  output  DATA_W  registered read data.
REQ-015 r_valid  output  1  one-cycle pulse qualifying r_data.
REQ-016 err  output  1  one-cycle pulse flagging an out-of-range access.

Function
REQ-017 FSM states CLEAR and RUN; rst forces CLEAR with clear pointer 0.
REQ-018 CLEAR: each cycle writes 0 to word[ptr], then ptr+1; after writing DEPTH-1 the FSM moves to RUN; the sequence takes exactly DEPTH cycles.
REQ-019 busy = 1 in CLEAR, 0 in RUN.
REQ-020 In CLEAR, w_en, r_en and clr_req are ignored: no write, r_valid=0, err=0.
REQ-021 clr_req in RUN moves to CLEAR with ptr=0 on the next edge; any w_en or r_en in that same cycle is still serviced.
REQ-022 Write: w_en=1 in RUN with w_addr<DEPTH updates word[w_addr] at the edge.
REQ-023 Read latency is 1 cycle: r_en=1 in cycle N sets r_data and r_valid=1 after edge N.
REQ-024 r_data holds its last value when there is no read; r_valid returns to 0.
REQ-025 Same cycle w_en and r_en with w_addr==r_addr: r_data = w_data if WRITE_FIRST=1, otherwise the prior stored word.
REQ-026 Address >= DEPTH on a write: the write is dropped and err pulses 1 the next cycle.
REQ-027 Address >= DEPTH on a read: r_data=0, r_valid=1 and err=1 the next cycle.
REQ-028 Both ports out of range in one cycle raise a single err pulse.
REQ-029 Write data wider or narrower than DATA_W does not exist; all storage is exactly DATA_W bits, with no truncation or extension.

Reset
REQ-030 Asserting rst, including mid-CLEAR or mid-read, sets busy=1, r_data=0, r_valid=0, err=0, state CLEAR and ptr=0.
REQ-031 The storage array has no reset term; the post-reset CLEAR sequence zeroes it, so it maps to block RAM.
REQ-032 Deasserting rst starts the DEPTH-cycle clear on the first rising edge.

Structure
REQ-033 Package dm_pkg holds the state enum (CLEAR, RUN) and default DATA_W/ADDR_W/DEPTH constants.
REQ-034 One sub-module, dm_ram_sdp: a simple dual-port array with 1 write port and 1 registered read port, parametrised by DATA_W, DEPTH and WRITE_FIRST.
REQ-035 data_mem_sdp contains the FSM, clear pointer, write mux (clear vs. user), range checks and err/r_valid registers.

Verification
REQ-036 Release rst, hold r_en=0 -> busy=1 for exactly 256 cycles, then 0; reading addresses 0, 127 and 255 returns 0x00.
REQ-037 After clear, write 0xA5 to 0x10, then read 0x10 next cycle -> r_data=0xA5 and r_valid=1 one cycle after r_en.
REQ-038 Same-cycle write 0x3C to 0x20 (holding 0x11) and read 0x20 -> r_data=0x3C with WRITE_FIRST=1, 0x11 with WRITE_FIRST=0.
REQ-039 DEPTH=200: write addr 210 -> err pulse and no array change; read addr 210 -> r_data=0, r_valid=1, err=1.
REQ-040 Write 0xFF to 0x05, pulse clr_req, attempt write at cycle 3 of clear -> busy=1 for DEPTH cycles, write ignored, read 0x05 returns 0x00.
REQ-041 Assert rst at cycle 100 of the clear -> busy stays 1, clear restarts at ptr 0 and completes DEPTH cycles after rst release.
